keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_encoder.sv | 170 +++++++++++++++++
 tb/tb_keypad_encoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces a single
// pressed key, emits its 4-bit code once with a one-cycle ready strobe.
module keypad_encoder #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       Clock,
    input  logic       clearIn,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] tecla,
    output logic       ready,
    output logic       keyHeld,
    output logic [2:0] estate
);

    typedef enum logic [2:0] {
        SCAN     = 3'b000,
        DEBOUNCE = 3'b001,
        EMIT     = 3'b010,
        HOLD     = 3'b011,
        RELEASE  = 3'b100
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] colIdx_q, colIdx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] captured_q, captured_d;
    logic [3:0] tecla_q, tecla_d;
    logic [3:0] rowsMeta_q, rowsSync_q;
    logic       ready_q, keyHeld_q;

    function automatic logic singleLow(input logic [3:0] p);
        case (p)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: singleLow = 1'b1;
            default:                            singleLow = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] rowOf(input logic [3:0] p);
        case (p)
            4'b1101: rowOf = 2'd1;
            4'b1011: rowOf = 2'd2;
            4'b0111: rowOf = 2'd3;
            default: rowOf = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] keyCode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: keyCode = 4'h1;
            4'h1: keyCode = 4'h2;
            4'h2: keyCode = 4'h3;
            4'h3: keyCode = 4'hC;
            4'h4: keyCode = 4'h4;
            4'h5: keyCode = 4'h5;
            4'h6: keyCode = 4'h6;
            4'h7: keyCode = 4'hB;
            4'h8: keyCode = 4'h7;
            4'h9: keyCode = 4'h8;
            4'hA: keyCode = 4'h9;
            4'hB: keyCode = 4'hF;
            4'hC: keyCode = 4'hE;
            4'hD: keyCode = 4'h0;
            4'hE: keyCode = 4'hD;
            default: keyCode = 4'hA;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        colIdx_d   = colIdx_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        tecla_d    = tecla_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = 8'd0;
                    if (singleLow(rowsSync_q)) begin
                        state_d    = DEBOUNCE;
                        captured_d = rowsSync_q;
                    end else begin
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DEBOUNCE: begin
                if (rowsSync_q == captured_q) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = EMIT;
                        cnt_d   = 8'd0;
                        tecla_d = keyCode(rowOf(captured_q), colIdx_q);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d  = SCAN;
                    colIdx_d = colIdx_q + 2'd1;
                    cnt_d    = 8'd0;
                end
            end
            EMIT: begin
                state_d = HOLD;
                cnt_d   = 8'd0;
            end
            HOLD: begin
                cnt_d = 8'd0;
                if (rowsSync_q == 4'hF) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rowsSync_q == 4'hF) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d  = SCAN;
                        colIdx_d = colIdx_q + 2'd1;
                        cnt_d    = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ready and keyHeld are registered from the next state so they are clean flop outputs
    always_ff @(posedge Clock or negedge clearIn) begin
        if (!clearIn) begin
            state_q    <= SCAN;
            colIdx_q   <= 2'd0;
            cnt_q      <= 8'd0;
            captured_q <= 4'hF;
            tecla_q    <= 4'h0;
            rowsMeta_q <= 4'hF;
            rowsSync_q <= 4'hF;
            ready_q    <= 1'b0;
            keyHeld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            colIdx_q   <= colIdx_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            tecla_q    <= tecla_d;
            rowsMeta_q <= rows;
            rowsSync_q <= rowsMeta_q;
            ready_q    <= (state_d == EMIT);
            keyHeld_q  <= (state_d == EMIT) || (state_d == HOLD) || (state_d == RELEASE);
        end
    end

    assign cols    = ~(4'b0001 << colIdx_q);
    assign tecla   = tecla_q;
    assign ready   = ready_q;
    assign keyHeld = keyHeld_q;
    assign estate  = state_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: a behavioural keypad matrix plus
// key-level expectations (one strobe per press, mapped code, hold/release timing).
module tb_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic       Clock   = 1'b0;
    logic       clearIn = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] tecla;
    logic       ready;
    logic       keyHeld;
    logic [2:0] estate;

    logic [15:0] pressMask = 16'h0000;
    int          errors = 0;
    int          checks = 0;
    int          strobeCount = 0;
    logic [3:0]  strobeCodes[$];
    logic [3:0]  codeMap[16] = '{4'h1, 4'h2, 4'h3, 4'hC,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hF,
                                 4'hE, 4'h0, 4'hD, 4'hA};

    keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .Clock   (Clock),
        .clearIn (clearIn),
        .rows    (rows),
        .cols    (cols),
        .tecla   (tecla),
        .ready   (ready),
        .keyHeld (keyHeld),
        .estate  (estate)
    );

    always #5 Clock = ~Clock;

    // A pressed key pulls its row low only while its column is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressMask[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(negedge Clock) begin
        if (ready) begin
            strobeCount = strobeCount + 1;
            strobeCodes.push_back(tecla);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cols"}, cols, 4'b1110);
        checkOutput({tag, "_tecla"}, tecla, 4'h0);
        checkOutput({tag, "_ready"}, ready, 1'b0);
        checkOutput({tag, "_keyHeld"}, keyHeld, 1'b0);
        checkOutput({tag, "_estate"}, estate, 3'b000);
    endtask

    // Waits for the strobe of an already-pressed key, holds, releases, checks release timing
    task automatic completeKey(input int r, input int c, input int holdCycles);
        logic [3:0] code;
        logic [3:0] colMask;
        int waited;
        code    = codeMap[r*4+c];
        colMask = ~(4'b0001 << c);
        waited  = 0;
        while (!ready && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        checkOutput("strobeInTime", waited < 200, 1'b1);
        checkOutput("teclaAtStrobe", tecla, code);
        checkOutput("keyHeldAtStrobe", keyHeld, 1'b1);
        checkOutput("colAtStrobe", cols, colMask);
        repeat (holdCycles) @(negedge Clock);
        checkOutput("colFrozenHold", cols, colMask);
        checkOutput("keyHeldHold", keyHeld, 1'b1);
        pressMask = 16'h0000;
        repeat (DEB) @(negedge Clock);
        checkOutput("keyHeldAfterRelease", keyHeld, 1'b1);
        waited = 0;
        while (keyHeld && waited < 20) begin
            @(negedge Clock);
            waited++;
        end
        checkOutput("keyHeldFell", keyHeld, 1'b0);
        repeat (5) @(negedge Clock);
        checkOutput("strobeCount", strobeCount, 1);
        checkOutput("teclaKept", tecla, code);
    endtask

    task automatic applyStimulus(input int r, input int c, input int holdCycles, input bit bounce);
        strobeCount = 0;
        if (bounce) begin
            repeat (4) begin
                pressMask[r*4+c] = 1'b1;
                repeat (3) @(negedge Clock);
                pressMask[r*4+c] = 1'b0;
                repeat (2) @(negedge Clock);
            end
            checkOutput("bounceNoStrobe", strobeCount, 0);
        end
        pressMask[r*4+c] = 1'b1;
        completeKey(r, c, holdCycles);
    endtask

    task automatic multiKey(input int c, input int keepRow, input int dropRow);
        strobeCount = 0;
        pressMask[keepRow*4+c] = 1'b1;
        pressMask[dropRow*4+c] = 1'b1;
        repeat (100) @(negedge Clock);
        checkOutput("multiNoStrobe", strobeCount, 0);
        pressMask[dropRow*4+c] = 1'b0;
        completeKey(keepRow, c, 30);
    endtask

    initial begin
        int r, c, r2, waited;
        logic [3:0] expCols;

        #3;
        checkResetValues("reset");
        @(negedge Clock);
        clearIn = 1'b1;

        // Idle scan: column k/SCAN_DIV mod 4 after the k-th edge
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            expCols = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            checkOutput("idleCols", cols, expCols);
        end
        checkOutput("idleNoStrobe", strobeCount, 0);

        applyStimulus(1, 1, 200, 1'b0);
        applyStimulus(2, 3, 50, 1'b1);
        multiKey(0, 0, 3);

        strobeCodes.delete();
        applyStimulus(0, 0, 20, 1'b0);
        applyStimulus(0, 3, 20, 1'b0);
        applyStimulus(0, 1, 20, 1'b0);
        applyStimulus(3, 2, 20, 1'b0);
        checkOutput("seqLen", strobeCodes.size(), 4);
        if (strobeCodes.size() == 4) begin
            checkOutput("seq0", strobeCodes[0], 4'h1);
            checkOutput("seq1", strobeCodes[1], 4'hC);
            checkOutput("seq2", strobeCodes[2], 4'h2);
            checkOutput("seq3", strobeCodes[3], 4'hD);
        end

        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            applyStimulus(r, c, $urandom_range(20, 150), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 2; i++) begin
            c  = $urandom_range(0, 3);
            r  = $urandom_range(0, 3);
            r2 = (r + $urandom_range(1, 3)) % 4;
            multiKey(c, r, r2);
        end

        // Reset during debounce of key 9
        strobeCount = 0;
        pressMask[2*4+2] = 1'b1;
        waited = 0;
        while (estate != 3'b001 && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        checkOutput("reachedDebounce", estate, 3'b001);
        #2 clearIn = 1'b0;
        #1 checkResetValues("rstDebounce");
        repeat (3) @(negedge Clock);
        clearIn = 1'b1;
        checkOutput("rstDebounceNoStrobe", strobeCount, 0);
        completeKey(2, 2, 30);

        // Reset in the strobe cycle of key 6, key held across reset
        strobeCount = 0;
        pressMask[1*4+2] = 1'b1;
        waited = 0;
        while (!ready && waited < 200) begin
            @(negedge Clock);
            waited++;
        end
        checkOutput("reachedEmit", ready, 1'b1);
        #1 clearIn = 1'b0;
        #1 checkResetValues("rstEmit");
        strobeCount = 0;
        repeat (3) @(negedge Clock);
        clearIn = 1'b1;
        completeKey(1, 2, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
